vliw_issue_ctrl: RTL

- Issue controller in front of the two-slot VLIW ALU datapath.
- Buffers 32-bit bundles from an upstream requester in a small FIFO.
- Detects read-after-write hazards against bundles still in flight, inserts NOP bubbles when needed, and drives the datapath `instruction` bus from a register.
- Keeps issue/stall statistics for debug.

---
 rtl/vliw_pkg.sv | 40 ++++
 rtl/vliw_issue_ctrl_if.sv | 12 +
 rtl/vliw_bundle_fifo.sv | 58 +++++
 rtl/vliw_issue_ctrl.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/vliw_pkg.sv
// Shared definitions for the VLIW issue controller.
// Bundle field positions, ALU opcodes, default scratch register and NOP
// bundle, issue FSM state encoding.
package vliw_pkg;

    // Bundle layout: op1 | op2 | dst1 | dst2 | srcA | srcB
    localparam int OP1_MSB  = 31;
    localparam int OP1_LSB  = 24;
    localparam int OP2_MSB  = 23;
    localparam int OP2_LSB  = 16;
    localparam int DST1_MSB = 15;
    localparam int DST1_LSB = 12;
    localparam int DST2_MSB = 11;
    localparam int DST2_LSB = 8;
    localparam int SRCA_MSB = 7;
    localparam int SRCA_LSB = 4;
    localparam int SRCB_MSB = 3;
    localparam int SRCB_LSB = 0;

    localparam logic [7:0] OP_ADD = 8'h00;
    localparam logic [7:0] OP_SUB = 8'h01;
    localparam logic [7:0] OP_AND = 8'h02;
    localparam logic [7:0] OP_OR  = 8'h03;
    localparam logic [7:0] OP_XOR = 8'h04;
    localparam logic [7:0] OP_NOT = 8'h05;
    localparam logic [7:0] OP_NOP = 8'hFF;

    localparam logic [3:0]  SCRATCH_REG_DEF = 4'hF;
    localparam logic [31:0] NOP_BUNDLE_DEF  =
        {OP_NOP, OP_NOP, SCRATCH_REG_DEF, SCRATCH_REG_DEF, 8'h00};

    typedef logic [31:0] bundle_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_STALL = 2'd2
    } issue_state_t;

endpackage

// File: rtl/vliw_issue_ctrl_if.sv
// Upstream bundle handshake into the issue controller.
//   in_valid  : source has a bundle
//   in_bundle : 32-bit VLIW bundle
//   in_ready  : controller can accept (FIFO not full)
interface vliw_issue_ctrl_if;
    logic        in_valid;
    logic [31:0] in_bundle;
    logic        in_ready;

    modport master (output in_valid, output in_bundle, input in_ready);
    modport slave  (input in_valid, input in_bundle, output in_ready);
endinterface

// File: rtl/vliw_bundle_fifo.sv
// Synchronous bundle FIFO with occupancy count and flush.
//   clk, rst     : clock, async active-high reset
//   flush        : empty the FIFO at the next edge; wins over push/pop
//   push, wdata  : write request (ignored when full)
//   pop, rdata   : read request (ignored when empty); rdata is the head
//   empty, full  : status
//   count        : occupancy 0..DEPTH
module vliw_bundle_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/vliw_issue_ctrl.sv
// Issue controller for the two-slot VLIW ALU datapath.
// Queues upstream bundles, holds back a head bundle that reads a register
// still being produced by an in-flight bundle, and drives the datapath
// instruction bus from a register (NOP bundle when nothing issues).
//   clk, rst     : clock, async active-high reset
//   up           : upstream bundle handshake (slave side)
//   flush        : drop all queued bundles
//   instruction  : registered bundle to the datapath
//   issue_fire   : instruction holds a real bundle
//   stall        : head bundle blocked by a hazard this cycle
//   dual_dst_err : issued bundle has dst1 == dst2
//   fifo_count   : queue occupancy
//   issued_cnt   : saturating count of issued bundles
//   stall_cnt    : saturating count of hazard-stall cycles
module vliw_issue_ctrl
    import vliw_pkg::*;
#(
    parameter int          DEPTH       = 4,
    parameter int          RESULT_LAT  = 2,
    parameter logic [3:0]  SCRATCH_REG = SCRATCH_REG_DEF,
    parameter logic [31:0] NOP_BUNDLE  = {8'hFF, 8'hFF, SCRATCH_REG, SCRATCH_REG, 8'h00}
) (
    input  logic                   clk,
    input  logic                   rst,
    vliw_issue_ctrl_if.slave       up,
    input  logic                   flush,
    output logic [31:0]            instruction,
    output logic                   issue_fire,
    output logic                   stall,
    output logic                   dual_dst_err,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic [15:0]            issued_cnt,
    output logic [15:0]            stall_cnt
);
    // A producer on `instruction` is visible to the next RESULT_LAT-1 heads.
    localparam int SB_N = RESULT_LAT - 1;
    localparam int SB_W = (SB_N > 0) ? SB_N : 1;

    issue_state_t state, state_nx;

    bundle_t    head;
    logic       fifo_empty;
    logic       fifo_full;
    logic       push;
    logic       pop;
    logic       hazard;
    bundle_t    instr_nx;
    logic [3:0] src_a, src_b, head_dst1, head_dst2;

    logic [SB_W-1:0]       sb_vld;
    logic [SB_W-1:0][3:0]  sb_dst1;
    logic [SB_W-1:0][3:0]  sb_dst2;

    assign up.in_ready = !fifo_full;
    assign push        = up.in_valid && up.in_ready;

    vliw_bundle_fifo #(.DEPTH(DEPTH), .WIDTH(32)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (push),
        .wdata (up.in_bundle),
        .pop   (pop),
        .rdata (head),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    assign src_a     = head[SRCA_MSB:SRCA_LSB];
    assign src_b     = head[SRCB_MSB:SRCB_LSB];
    assign head_dst1 = head[DST1_MSB:DST1_LSB];
    assign head_dst2 = head[DST2_MSB:DST2_LSB];

    // Scratch register is a don't-care sink; s==d with s!=scratch also
    // excludes a scratch destination.
    function automatic logic hit(input logic [3:0] s, input logic [3:0] d);
        return (s == d) && (s != SCRATCH_REG);
    endfunction

    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < SB_N; i++) begin
            if (sb_vld[i] && (hit(src_a, sb_dst1[i]) || hit(src_a, sb_dst2[i]) ||
                              hit(src_b, sb_dst1[i]) || hit(src_b, sb_dst2[i])))
                hazard = 1'b1;
        end
    end

    // Next action is decided fresh each cycle; flush suppresses any issue.
    always_comb begin
        state_nx = ST_IDLE;
        if (!flush && !fifo_empty)
            state_nx = hazard ? ST_STALL : ST_ISSUE;
    end

    assign pop      = (state_nx == ST_ISSUE);
    assign stall    = (state_nx == ST_STALL);
    assign instr_nx = pop ? head : NOP_BUNDLE;

    // `state` remembers what was registered onto `instruction` last edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    assign issue_fire = (state == ST_ISSUE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instruction  <= NOP_BUNDLE;
            dual_dst_err <= 1'b0;
            issued_cnt   <= '0;
            stall_cnt    <= '0;
        end else begin
            instruction  <= instr_nx;
            dual_dst_err <= pop && (head_dst1 == head_dst2);
            if (pop && issued_cnt != 16'hFFFF)  issued_cnt <= issued_cnt + 16'd1;
            if (stall && stall_cnt != 16'hFFFF) stall_cnt  <= stall_cnt + 16'd1;
        end
    end

    // Scoreboard is deliberately left alone on flush: issued bundles still
    // write back.
    generate
        if (SB_N > 0) begin : g_sb
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sb_vld  <= '0;
                    sb_dst1 <= '0;
                    sb_dst2 <= '0;
                end else begin
                    sb_vld[0]  <= pop;
                    sb_dst1[0] <= head_dst1;
                    sb_dst2[0] <= head_dst2;
                    for (int i = 1; i < SB_N; i++) begin
                        sb_vld[i]  <= sb_vld[i-1];
                        sb_dst1[i] <= sb_dst1[i-1];
                        sb_dst2[i] <= sb_dst2[i-1];
                    end
                end
            end
        end else begin : g_no_sb
            assign sb_vld  = '0;
            assign sb_dst1 = '0;
            assign sb_dst2 = '0;
        end
    endgenerate

endmodule
